// File: rtl/npn_pkg.sv
// Shared types and the NPN input mapping for the truth-table sweeper.
// perm_t element k holds the source-index select p_k for FUT input k.
package npn_pkg;

    typedef logic [15:0]     tt_t;
    typedef logic [3:0]      minterm_t;
    typedef logic [3:0][1:0] perm_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // fut_x[k] = idx[p_k] ^ neg[k]; duplicate selects are allowed.
    function automatic minterm_t apply_npn_in(minterm_t idx, perm_t perm, logic [3:0] neg);
        minterm_t r;
        for (int k = 0; k < 4; k++) begin
            r[k] = idx[perm[k]] ^ neg[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/npn_tt_sweeper_if.sv
// Host-side control/result bundle of the truth-table sweeper.
// The host drives master; the sweeper implements slave.
interface npn_tt_sweeper_if;
    import npn_pkg::*;

    logic       start;
    logic       abort;
    logic [7:0] cfg_perm;
    logic [3:0] cfg_neg_in;
    logic       cfg_neg_out;
    tt_t        expect_tt;
    logic       busy;
    logic       done;
    tt_t        tt;
    logic       match;
    minterm_t   mism_idx;

    modport master (
        output start, abort, cfg_perm, cfg_neg_in, cfg_neg_out, expect_tt,
        input  busy, done, tt, match, mism_idx
    );

    modport slave (
        input  start, abort, cfg_perm, cfg_neg_in, cfg_neg_out, expect_tt,
        output busy, done, tt, match, mism_idx
    );

endinterface

// File: rtl/npn_tt_compare.sv
// Combinational truth-table check: equality plus the lowest mismatching minterm.
module npn_tt_compare
    import npn_pkg::*;
(
    input  tt_t      tt,
    input  tt_t      expect_tt,
    output logic     match,
    output minterm_t mism_idx
);
    tt_t diff;
    tt_t first_diff;

    assign diff  = tt ^ expect_tt;
    assign match = ~|diff;

    // One-hot isolate the lowest set bit of diff.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_diff[gi] = diff[gi];
            end else begin : g_upper
                assign first_diff[gi] = diff[gi] & ~|diff[gi-1:0];
            end
        end
    endgenerate

    always_comb begin
        mism_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (first_diff[i]) begin
                mism_idx = mism_idx | 4'(i);
            end
        end
    end

endmodule

// File: rtl/npn_tt_sweeper.sv
// Walks the 16 minterms through an NPN transform into the FUT, samples fut_y after
// SETTLE_CYCLES per minterm, and reports the captured truth table against an expected one.
module npn_tt_sweeper
    import npn_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    npn_tt_sweeper_if.slave  host,
    output minterm_t         fut_x,
    input  logic             fut_y
);
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg,   state_next;
    minterm_t    idx_reg,     idx_next;
    logic [3:0]  cnt_reg,     cnt_next;
    perm_t       perm_reg,    perm_next;
    logic [3:0]  neg_in_reg,  neg_in_next;
    logic        neg_out_reg, neg_out_next;
    tt_t         expect_reg,  expect_next;
    logic [14:0] shadow_reg,  shadow_next;
    minterm_t    fut_x_reg,   fut_x_next;
    tt_t         tt_reg,      tt_next;
    logic        match_reg,   match_next;
    minterm_t    mism_reg,    mism_next;

    logic        sample_bit;
    tt_t         final_tt;
    logic        cmp_match;
    minterm_t    cmp_mism;

    // Minterm 15 is never stored in the shadow; it joins the table straight from fut_y.
    assign sample_bit = fut_y ^ neg_out_reg;
    assign final_tt   = {sample_bit, shadow_reg};

    npn_tt_compare u_compare (
        .tt        (final_tt),
        .expect_tt (expect_reg),
        .match     (cmp_match),
        .mism_idx  (cmp_mism)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            perm_reg    <= '0;
            neg_in_reg  <= '0;
            neg_out_reg <= 1'b0;
            expect_reg  <= '0;
            shadow_reg  <= '0;
            fut_x_reg   <= '0;
            tt_reg      <= '0;
            match_reg   <= 1'b0;
            mism_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            perm_reg    <= perm_next;
            neg_in_reg  <= neg_in_next;
            neg_out_reg <= neg_out_next;
            expect_reg  <= expect_next;
            shadow_reg  <= shadow_next;
            fut_x_reg   <= fut_x_next;
            tt_reg      <= tt_next;
            match_reg   <= match_next;
            mism_reg    <= mism_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        perm_next    = perm_reg;
        neg_in_next  = neg_in_reg;
        neg_out_next = neg_out_reg;
        expect_next  = expect_reg;
        shadow_next  = shadow_reg;
        fut_x_next   = fut_x_reg;
        tt_next      = tt_reg;
        match_next   = match_reg;
        mism_next    = mism_reg;

        case (state_reg)
            ST_IDLE: begin
                if (host.start && !host.abort) begin
                    perm_next    = host.cfg_perm;
                    neg_in_next  = host.cfg_neg_in;
                    neg_out_next = host.cfg_neg_out;
                    expect_next  = host.expect_tt;
                    idx_next     = '0;
                    cnt_next     = CNT_RELOAD;
                    fut_x_next   = apply_npn_in('0, host.cfg_perm, host.cfg_neg_in);
                    state_next   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Abort has priority, including over the final sample.
                if (host.abort) begin
                    fut_x_next = '0;
                    state_next = ST_IDLE;
                end else if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else if (idx_reg != 4'd15) begin
                    shadow_next[idx_reg] = sample_bit;
                    idx_next             = idx_reg + 4'd1;
                    fut_x_next           = apply_npn_in(idx_reg + 4'd1, perm_reg, neg_in_reg);
                    cnt_next             = CNT_RELOAD;
                end else begin
                    tt_next    = final_tt;
                    match_next = cmp_match;
                    mism_next  = cmp_mism;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                fut_x_next = '0;
                state_next = ST_IDLE;
            end
            default: begin
                fut_x_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fut_x         = fut_x_reg;
    assign host.busy     = (state_reg != ST_IDLE);
    assign host.done     = (state_reg == ST_DONE);
    assign host.tt       = tt_reg;
    assign host.match    = match_reg;
    assign host.mism_idx = mism_reg;

endmodule

// File: tb/tb_npn_tt_sweeper.sv
// Scoreboarded bench for npn_tt_sweeper: two instances (SETTLE_CYCLES 1 and 3), each
// driving a table-lookup FUT, checked against a minterm-by-minterm reference model.
module tb_npn_tt_sweeper;

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [3:0]  mism;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  fut_x1, fut_x3;
    logic        fut_y1, fut_y3;
    logic [15:0] tbl1, tbl3;
    int          cyc;
    int          errors;
    int          checks;
    int          n_done1, n_done3;
    logic [15:0] last_tt1;
    exp_t        q1[$];
    exp_t        q3[$];

    npn_tt_sweeper_if s1();
    npn_tt_sweeper_if s3();

    npn_tt_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (s1),
        .fut_x (fut_x1),
        .fut_y (fut_y1)
    );

    npn_tt_sweeper #(.SETTLE_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (s3),
        .fut_x (fut_x3),
        .fut_y (fut_y3)
    );

    // Function under test: arbitrary 4-input function given as a lookup table.
    assign fut_y1 = tbl1[fut_x1];
    assign fut_y3 = tbl3[fut_x3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: evaluate each minterm's mapped input on the FUT table directly.
    function automatic logic [15:0] model_tt(input logic [7:0] perm, input logic [3:0] ni,
                                             input logic no, input logic [15:0] tbl);
        logic [15:0] r;
        logic [3:0]  iv;
        logic [3:0]  x;
        logic [1:0]  sel;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            for (int k = 0; k < 4; k++) begin
                sel  = perm[2*k +: 2];
                x[k] = iv[sel] ^ ni[k];
            end
            r[i] = tbl[x] ^ no;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_mism(input logic [15:0] t, input logic [15:0] e);
        logic [3:0] m;
        m = '0;
        for (int i = 15; i >= 0; i--) begin
            if (t[i] != e[i]) m = 4'(i);
        end
        return m;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] perm, input logic [3:0] ni,
                                      input logic no, input logic [15:0] e,
                                      input logic [15:0] tbl, input int acc);
        exp_t x;
        x.tt    = model_tt(perm, ni, no, tbl);
        x.match = (x.tt == e);
        x.mism  = model_mism(x.tt, e);
        x.acc   = acc;
        return x;
    endfunction

    // Scoreboard monitors: compare whenever a DUT reports done.
    always @(negedge clk) begin
        if (rst_n && s1.done) begin
            exp_t e;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got done=1 expected no done (tt=%0h)", s1.tt);
            end else begin
                e = q1.pop_front();
                n_done1++;
                $display("dut1 sweep %0d: tt=%04h match=%0d mism_idx=%0d (exp tt=%04h)",
                         n_done1, s1.tt, s1.match, s1.mism_idx, e.tt);
                chk("tt1", 32'(s1.tt), 32'(e.tt));
                chk("match1", 32'(s1.match), 32'(e.match));
                chk("mism1", 32'(s1.mism_idx), 32'(e.mism));
                chk("latency1", 32'(cyc - e.acc), 32'd16);
                last_tt1 = e.tt;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s3.done) begin
            exp_t e;
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done3: got done=1 expected no done (tt=%0h)", s3.tt);
            end else begin
                e = q3.pop_front();
                n_done3++;
                $display("dut3 sweep %0d: tt=%04h match=%0d mism_idx=%0d (exp tt=%04h)",
                         n_done3, s3.tt, s3.match, s3.mism_idx, e.tt);
                chk("tt3", 32'(s3.tt), 32'(e.tt));
                chk("match3", 32'(s3.match), 32'(e.match));
                chk("mism3", 32'(s3.mism_idx), 32'(e.mism));
                chk("latency3", 32'(cyc - e.acc), 32'd48);
            end
        end
    end

    task automatic scramble_cfg1();
        s1.cfg_perm    = 8'($urandom);
        s1.cfg_neg_in  = 4'($urandom);
        s1.cfg_neg_out = 1'($urandom);
        s1.expect_tt   = 16'($urandom);
    endtask

    task automatic wait_idle1();
        for (int n = 0; n < 60 && s1.busy; n++) @(negedge clk);
        chk("idle_timeout1", 32'(s1.busy), 32'd0);
    endtask

    // Accept-only start on dut1 (no expectation pushed); used before abort/reset.
    task automatic start_only1(input logic [7:0] perm, input logic [3:0] ni, input logic [15:0] tbl);
        @(negedge clk);
        tbl1 = tbl;
        s1.cfg_perm = perm; s1.cfg_neg_in = ni; s1.cfg_neg_out = 1'b0; s1.expect_tt = 16'h0;
        s1.start = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy1", 32'(s1.busy), 32'd1);
        s1.start = 1'b0;
    endtask

    task automatic wait_fut_x1(input logic [3:0] v);
        int n;
        for (n = 0; n < 40 && fut_x1 != v; n++) @(negedge clk);
        chk("wait_minterm1", 32'(fut_x1), 32'(v));
    endtask

    task automatic run_sweep1(input logic [7:0] perm, input logic [3:0] ni, input logic no,
                              input logic [15:0] e, input logic [15:0] tbl);
        @(negedge clk);
        tbl1 = tbl;
        s1.cfg_perm = perm; s1.cfg_neg_in = ni; s1.cfg_neg_out = no; s1.expect_tt = e;
        s1.start = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy1", 32'(s1.busy), 32'd1);
        chk("accept_fut_x1", 32'(fut_x1), 32'(ni));
        q1.push_back(make_exp(perm, ni, no, e, tbl, cyc));
        s1.start = 1'b0;
        scramble_cfg1();
        wait_idle1();
    endtask

    task automatic abort_check1(input string tag);
        @(posedge clk); #1;
        chk({tag, "_busy"}, 32'(s1.busy), 32'd0);
        chk({tag, "_done"}, 32'(s1.done), 32'd0);
        chk({tag, "_fut_x"}, 32'(fut_x1), 32'd0);
        chk({tag, "_tt"}, 32'(s1.tt), 32'(last_tt1));
        s1.abort = 1'b0;
    endtask

    initial begin
        logic [15:0] t, e, tb;
        logic [7:0]  p;
        logic [3:0]  ni;
        logic        no;
        int          acc3;

        errors = 0; checks = 0; cyc = 0; n_done1 = 0; n_done3 = 0; last_tt1 = '0;
        tbl1 = '0; tbl3 = '0;
        rst_n = 1'b0;
        s1.start = 1'b0; s1.abort = 1'b0; s1.cfg_perm = '0; s1.cfg_neg_in = '0;
        s1.cfg_neg_out = 1'b0; s1.expect_tt = '0;
        s3.start = 1'b0; s3.abort = 1'b0; s3.cfg_perm = '0; s3.cfg_neg_in = '0;
        s3.cfg_neg_out = 1'b0; s3.expect_tt = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fut_x1", 32'(fut_x1), 32'd0);
        chk("rst_busy1", 32'(s1.busy), 32'd0);
        chk("rst_done1", 32'(s1.done), 32'd0);
        chk("rst_tt1", 32'(s1.tt), 32'd0);
        chk("rst_match1", 32'(s1.match), 32'd0);
        chk("rst_mism1", 32'(s1.mism_idx), 32'd0);
        chk("rst_busy3", 32'(s3.busy), 32'd0);
        chk("rst_fut_x3", 32'(fut_x3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: y=x0 identity, AND with output negation, permuted and negated inputs.
        run_sweep1(8'hE4, 4'b0000, 1'b0, 16'hAAAA, 16'hAAAA);
        run_sweep1(8'hE4, 4'b0000, 1'b1, 16'h8000, 16'h8000);
        run_sweep1(8'h27, 4'b0000, 1'b0, 16'hFF00, 16'hAAAA);
        run_sweep1(8'hE4, 4'b0001, 1'b0, 16'h5555, 16'hAAAA);

        // Randomized sweeps: expect equals, single-bit-off, or unrelated table.
        for (int n = 0; n < 10; n++) begin
            p  = 8'($urandom);
            ni = 4'($urandom);
            no = 1'($urandom);
            tb = 16'($urandom);
            t  = model_tt(p, ni, no, tb);
            case ($urandom_range(0, 2))
                0:       e = t;
                1:       e = t ^ (16'h1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            run_sweep1(p, ni, no, e, tb);
        end

        // Aborts: mid-sweep and coincident with the final sample.
        run_sweep1(8'hE4, 4'b0000, 1'b0, 16'hAAAA, 16'hAAAA);
        start_only1(8'hE4, 4'b0000, 16'h8000);
        wait_fut_x1(4'd7);
        s1.abort = 1'b1;
        abort_check1("abort_mid");
        start_only1(8'hE4, 4'b0000, 16'h8000);
        wait_fut_x1(4'd15);
        s1.abort = 1'b1;
        abort_check1("abort_final");
        repeat (3) @(negedge clk);

        // start together with abort in IDLE is not accepted.
        s1.start = 1'b1; s1.abort = 1'b1;
        @(posedge clk); #1;
        chk("start_abort_idle_busy", 32'(s1.busy), 32'd0);
        s1.start = 1'b0; s1.abort = 1'b0;

        // Asynchronous reset during minterm 9.
        start_only1(8'hE4, 4'b0000, 16'h1234);
        wait_fut_x1(4'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fut_x1", 32'(fut_x1), 32'd0);
        chk("arst_busy1", 32'(s1.busy), 32'd0);
        chk("arst_done1", 32'(s1.done), 32'd0);
        chk("arst_tt1", 32'(s1.tt), 32'd0);
        chk("arst_match1", 32'(s1.match), 32'd0);
        chk("arst_mism1", 32'(s1.mism_idx), 32'd0);
        last_tt1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tb = 16'($urandom);
        run_sweep1(8'hE4, 4'b0000, 1'b0, model_tt(8'hE4, 4'b0000, 1'b0, tb), tb);

        // SETTLE_CYCLES=3: hold time per minterm, start ignored in DONE, re-accept after.
        @(negedge clk);
        tbl3 = 16'($urandom);
        s3.cfg_perm = 8'hE4; s3.cfg_neg_in = 4'b0000; s3.cfg_neg_out = 1'b0;
        s3.expect_tt = 16'($urandom);
        s3.start = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy3", 32'(s3.busy), 32'd1);
        acc3 = cyc;
        q3.push_back(make_exp(8'hE4, 4'b0000, 1'b0, s3.expect_tt, tbl3, acc3));
        s3.start = 1'b0;
        for (int c = 0; c < 48; c++) begin
            chk("hold3", 32'(fut_x3), 32'(c / 3));
            @(posedge clk); #1;
        end
        chk("done3_at_48", 32'(s3.done), 32'd1);
        p  = 8'($urandom);
        ni = 4'($urandom);
        no = 1'($urandom);
        s3.cfg_perm = p; s3.cfg_neg_in = ni; s3.cfg_neg_out = no;
        s3.expect_tt = 16'($urandom);
        s3.start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", 32'(s3.busy), 32'd0);
        @(posedge clk); #1;
        chk("reaccept_busy3", 32'(s3.busy), 32'd1);
        chk("period3", 32'(cyc - acc3), 32'd50);
        chk("reaccept_fut_x3", 32'(fut_x3), 32'(ni));
        q3.push_back(make_exp(p, ni, no, s3.expect_tt, tbl3, cyc));
        s3.start = 1'b0;
        for (int n = 0; n < 80 && s3.busy; n++) @(negedge clk);
        chk("idle_timeout3", 32'(s3.busy), 32'd0);

        repeat (4) @(negedge clk);
        chk("pending1", 32'(q1.size()), 32'd0);
        chk("pending3", 32'(q3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
